// File: rtl/reg32_serial_reader.sv
// Captures a register word on request and streams it out LSB first over a valid/ready serial link.
// Optional feature: define READER_PARITY_EN to append an even-parity bit after the data bits.
module reg32_serial_reader #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             rd_en,
    input  logic [WIDTH-1:0] word_in,
    output logic             serial_data,
    output logic             serial_valid,
    input  logic             serial_ready,
    output logic             busy,
    output logic             done
);

`ifdef READER_PARITY_EN
    localparam int NBITS = WIDTH + 1;
`else
    localparam int NBITS = WIDTH;
`endif

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBITS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [NBITS-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d      = state_q;
        shreg_d      = shreg_q;
        cnt_d        = cnt_q;
        rd_en        = 1'b0;
        serial_valid = 1'b0;
        serial_data  = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_LOAD;
            end
            S_LOAD: begin
                rd_en = 1'b1;
                busy  = 1'b1;
`ifdef READER_PARITY_EN
                // Parity rides in the top bit, so it falls out after the data bits.
                shreg_d = {^word_in, word_in};
`else
                shreg_d = word_in;
`endif
                cnt_d   = '0;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                busy         = 1'b1;
                serial_valid = 1'b1;
                serial_data  = shreg_q[0];
                if (serial_ready) begin
                    shreg_d = shreg_q >> 1;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) state_d = S_DONE;
                end
            end
            S_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            // NOTE: the data path is cleared on reset too, so no stale word survives an abort.
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_reg32_serial_reader.sv
// Self-checking bench for reg32_serial_reader: directed and random transfers against a bit-stream model.
module tb_reg32_serial_reader;

    localparam int WIDTH = 32;
`ifdef READER_PARITY_EN
    localparam int NBITS = WIDTH + 1;
`else
    localparam int NBITS = WIDTH;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             rd_en;
    logic [WIDTH-1:0] word_in = '0;
    logic             serial_data;
    logic             serial_valid;
    logic             serial_ready = 1'b1;
    logic             busy;
    logic             done;

    int n_cmp = 0;
    int n_err = 0;

    reg32_serial_reader #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .rd_en        (rd_en),
        .word_in      (word_in),
        .serial_data  (serial_data),
        .serial_valid (serial_valid),
        .serial_ready (serial_ready),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference stream: data bits LSB first, then even parity of the word when enabled.
    function automatic logic exp_bit(input logic [WIDTH-1:0] w, input int i);
        if (i < WIDTH) return 1'((w >> i) & 1);
        return ^w;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, ".busy"}, 32'(busy), 0);
        check({tag, ".rd_en"}, 32'(rd_en), 0);
        check({tag, ".valid"}, 32'(serial_valid), 0);
        check({tag, ".data"}, 32'(serial_data), 0);
        check({tag, ".done"}, 32'(done), 0);
    endtask

    // One full transfer. After capture word_in is replaced by alt_word; the bit at stall_at
    // is held for stall_len cycles with serial_ready low; noise asserts start during SHIFT/DONE.
    task automatic transfer(input string tag, input logic [WIDTH-1:0] w, input logic [WIDTH-1:0] alt_word,
                            input int stall_at, input int stall_len, input bit noise);
        word_in = w;
        start   = 1'b1;
        step();
        check({tag, ".load_rd_en"}, 32'(rd_en), 1);
        check({tag, ".load_busy"}, 32'(busy), 1);
        check({tag, ".load_valid"}, 32'(serial_valid), 0);
        start = noise;
        step();
        word_in = alt_word;
        for (int i = 0; i < NBITS; i++) begin
            if (i == stall_at) begin
                serial_ready = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    check({tag, ".stall_valid"}, 32'(serial_valid), 1);
                    check({tag, ".stall_data"}, 32'(serial_data), 32'(exp_bit(w, i)));
                    step();
                end
                serial_ready = 1'b1;
            end
            check($sformatf("%s.valid%0d", tag, i), 32'(serial_valid), 1);
            check($sformatf("%s.bit%0d", tag, i), 32'(serial_data), 32'(exp_bit(w, i)));
            check($sformatf("%s.done_early%0d", tag, i), 32'(done), 0);
            step();
        end
        check({tag, ".done"}, 32'(done), 1);
        check({tag, ".done_busy"}, 32'(busy), 1);
        check({tag, ".done_valid"}, 32'(serial_valid), 0);
        step();
        start = 1'b0;
        check_idle({tag, ".idle"});
    endtask

    initial begin
        // Reset held for two cycles with start high.
        rst_n = 1'b0;
        start = 1'b1;
        step();
        step();
        check_idle("reset");
        start = 1'b0;
        rst_n = 1'b1;
        step();
        check_idle("post_reset");

        // Directed words: basic read, stall on bit 3, capture isolation, parity-sensitive words.
        transfer("basic", 32'hA5A5_0F0F, 32'hA5A5_0F0F, -1, 0, 1'b0);
        transfer("stall", 32'hA5A5_0F0F, 32'hA5A5_0F0F, 3, 5, 1'b0);
        transfer("isolate", 32'h0000_0001, 32'hFFFF_FFFF, -1, 0, 1'b0);
        transfer("ignore_start", 32'h8000_0003, 32'h1234_5678, -1, 0, 1'b1);
        step();
        check_idle("no_extra_xfer");

        // Random words, random stall points and lengths, back to back.
        for (int k = 0; k < 6; k++) begin
            transfer($sformatf("rand%0d", k), WIDTH'($urandom), WIDTH'($urandom),
                     int'($urandom_range(0, NBITS - 1)), int'($urandom_range(0, 3)), 1'(k & 1));
        end

        // Abort after 10 accepted bits.
        word_in = 32'hDEAD_BEEF;
        start   = 1'b1;
        step();
        start = 1'b0;
        step();
        for (int i = 0; i < 10; i++) begin
            check($sformatf("abort.bit%0d", i), 32'(serial_data), 32'(exp_bit(32'hDEAD_BEEF, i)));
            step();
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check_idle("abort");
        step();
        check_idle("abort_next");

        transfer("after_abort", WIDTH'($urandom), WIDTH'($urandom), 2, 1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
